booth_mac_acc: RTL and testbench
================================

// Module: booth_mac_acc
// PURPOSE
//   Accumulation stage directly downstream of booth2. Consumes a stream of signed
//   2*WIDTH-bit Booth products over a valid/ready handshake and sums one frame
//   (terminated by in_last) into a sign-extended accumulator. Presents the frame
//   sum, beat count and overflow flag on an output valid/ready handshake.
// PARAMETERS
//   WIDTH      4   operand width of the upstream booth2; product width = 2*WIDTH
//   ACC_WIDTH  16  accumulator width; must be >= 2*WIDTH (elaboration error otherwise)
//   CNT_WIDTH  8   width of the per-frame beat counter
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous, active-high reset
//   in_valid   in   1            in_p/in_last valid
//   in_ready   out  1            stage accepts a beat this cycle
//   in_p       in   2*WIDTH      signed product from booth2 (p)
//   in_last    in   1            beat is the final term of the frame
//   sat_en     in   1            1: saturate on overflow; 0: wrap (sampled per beat)
//   out_valid  out  1            frame result valid
//   out_ready  in   1            downstream accepts the result
//   out_acc    out  ACC_WIDTH    signed frame sum
//   out_count  out  CNT_WIDTH    beats in the frame (saturates at all-ones)
//   out_ovf    out  1            sticky: any accumulate in the frame overflowed
// BEHAVIOUR
//   - Reset (async assert, sync release): acc=0, count=0, ovf=0, out_valid=0, state=ACC.
//     in_ready=0 while rst is high; in_ready=1 from the first clock after release.
//   - FSM: ACC -> DONE on an accepted beat with in_last=1. DONE -> ACC on an
//     out_valid && out_ready handshake. No other transitions.
//   - in_ready = (state==ACC); out_valid = (state==DONE). Both are registered-state decodes.
//   - Beat accept (in_valid && in_ready): sum = acc + sext(in_p) at ACC_WIDTH+1 bits.
//     Signed overflow when the two top bits of sum differ. On overflow, ovf<=1 and
//     acc<=sat_en ? (sum<0 ? MIN : MAX) : sum[ACC_WIDTH-1:0]. Otherwise acc<=sum.
//     count<=count+1 unless count==all-ones; in that case count holds.
//   - Latency: out_valid rises on the clock after the in_last beat is accepted.
//     out_acc/out_count/out_ovf show the final values and stay stable while out_valid=1.
//   - Backpressure: in DONE, in_ready=0. Result and flags hold until out_ready.
//     On handshake, acc, count and ovf clear to 0 and the state returns to ACC.
//     in_ready reasserts on the next cycle, so there is no same-cycle bypass and
//     a one-cycle bubble between frames.
//   - out_acc/out_count/out_ovf are visible in ACC as the running values.
//     Downstream ignores them unless out_valid=1.
//   - in_p and in_last are ignored when the handshake does not occur.
//   - Reset asserted mid-frame or while in DONE discards the partial or pending
//     result immediately.
// STRUCTURE
//   - booth_pkg: localparams PROD_W=2*WIDTH; state enum ACC/DONE; ACC_MAX/ACC_MIN helpers.
//   - Sub-module booth_sat_add: combinational (ACC_WIDTH)+(PROD_W) signed add with
//     sat_en. Outputs result and ovf.
//   - Top holds the FSM, the acc/count/ovf registers and the handshake decode.
// TESTING (WIDTH=4 unless noted; bench drives booth2 -> booth_mac_acc)
//   1 Frame of three beats: products 2*5=10, 5*2=10, (-1)*(-5)=5, last on beat 3
//     -> out_acc=25 (0x0019), out_count=3, out_ovf=0, out_valid one cycle after beat 3.
//   2 Single-beat frame p=-5 (0xFB), in_last=1
//     -> out_acc=0xFFFB, out_count=1. out_valid=1 and in_ready=0 next cycle.
//   3 ACC_WIDTH=8, sat_en=1, two beats p=100 -> out_acc=127 (0x7F), out_ovf=1.
//     Same with sat_en=0 -> out_acc=0xC8 (-56), out_ovf=1.
//     Two beats p=-100 with sat_en=1 -> out_acc=0x80, out_ovf=1.
//   4 Backpressure: hold out_ready=0 for 5 cycles after frame 1, with in_valid held high
//     -> out_valid stays 1, in_ready stays 0, outputs stable, no beat consumed.
//     After the out_ready pulse: acc=0 and in_ready=1 on the next cycle.
//   5 Reset mid-frame: accept 10 then 10, assert rst asynchronously between clocks
//     -> out_acc=0, out_count=0, out_valid=0 immediately. The next frame {5} yields 5.
//   6 CNT_WIDTH=2: frame of six beats p=1 -> out_count=3 (saturated), out_acc=6.
//     in_valid gaps mid-frame do not change acc or count.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth accumulate stage.
// Holds the FSM state enum, default widths and MIN/MAX helpers.
package booth_pkg;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam int WIDTH_DEF     = 4;
  localparam int ACC_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF = 8;
  localparam int PROD_W_DEF    = 2 * WIDTH_DEF;

  // Most positive w-bit two's complement value
  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit two's complement value (low w bits)
  function automatic logic [63:0] acc_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Signed accumulator + product add with overflow detect and optional saturation.
// Ports: i_acc, i_p, i_sat_en in; o_sum, o_ovf out. Purely combinational.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int PROD_W    = PROD_W_DEF
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [PROD_W-1:0]    i_p,
  input  logic                 i_sat_en,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  localparam logic [ACC_WIDTH-1:0] MAXV =
    ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] MINV =
    ACC_WIDTH'(acc_min(ACC_WIDTH));

  logic [ACC_WIDTH:0] w_acc_x;
  logic [ACC_WIDTH:0] w_p_x;
  logic [ACC_WIDTH:0] w_sum;

  // One guard bit: the top two bits disagree only on signed overflow
  assign w_acc_x = {i_acc[ACC_WIDTH-1], i_acc};
  assign w_p_x   = {{(ACC_WIDTH + 1 - PROD_W){i_p[PROD_W-1]}}, i_p};
  assign w_sum   = w_acc_x + w_p_x;
  assign o_ovf   = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    o_sum = w_sum[ACC_WIDTH-1:0];
    if (o_ovf && i_sat_en) begin
      o_sum = w_sum[ACC_WIDTH] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/booth_mac_acc.sv
// Frame accumulator after booth2: sums signed products until in_last, then
// holds sum/count/ovf on out_valid until out_ready. Ports: clk, rst, in_*, out_*, sat_en.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_p,
  input  logic                 in_last,
  input  logic                 sat_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam int PROD_W = 2 * WIDTH;

  generate
    if (ACC_WIDTH < PROD_W) begin : g_bad_width
      $error("booth_mac_acc: ACC_WIDTH must be >= 2*WIDTH");
    end
  endgenerate

  state_t               r_state;
  state_t               w_next;
  logic                 r_live;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_ovf;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_ovf;
  logic                 w_beat;
  logic                 w_out_hs;

  booth_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .PROD_W    (PROD_W)
  ) u_add (
    .i_acc    (r_acc),
    .i_p      (in_p),
    .i_sat_en (sat_en),
    .o_sum    (w_sum),
    .o_ovf    (w_ovf)
  );

  // r_live keeps in_ready low until the first clock after reset release
  assign in_ready  = (r_state == ST_ACC) && r_live;
  assign out_valid = (r_state == ST_DONE);
  assign w_beat    = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

  assign out_acc   = r_acc;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_ACC:  if (w_beat && in_last) w_next = ST_DONE;
      ST_DONE: if (w_out_hs)          w_next = ST_ACC;
      default: w_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
      r_live  <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_beat) begin
        r_acc <= w_sum;
        if (w_ovf) r_ovf <= 1'b1;
        if (!(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      end else if (w_out_hs) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_mac_acc.sv
// Scoreboard bench for booth_mac_acc: three instances cover the default
// widths, an 8-bit accumulator and a 2-bit beat counter.
module tb_booth_mac_acc;

  typedef struct {
    logic [15:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv[3];
  logic       il[3];
  logic       sat[3];
  logic       ordy[3];
  logic [7:0] ip[3];
  wire        ird[3];
  wire        ov[3];
  wire        oovf[3];
  wire [15:0] acc0;
  wire [7:0]  acc1;
  wire [15:0] acc2;
  wire [7:0]  cnt0;
  wire [7:0]  cnt1;
  wire [1:0]  cnt2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mac_acc #(.WIDTH(4), .ACC_WIDTH(16), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ird[0]),
    .in_p(ip[0]), .in_last(il[0]), .sat_en(sat[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_acc(acc0),
    .out_count(cnt0), .out_ovf(oovf[0]));

  booth_mac_acc #(.WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ird[1]),
    .in_p(ip[1]), .in_last(il[1]), .sat_en(sat[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_acc(acc1),
    .out_count(cnt1), .out_ovf(oovf[1]));

  booth_mac_acc #(.WIDTH(4), .ACC_WIDTH(16), .CNT_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ird[2]),
    .in_p(ip[2]), .in_last(il[2]), .sat_en(sat[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_acc(acc2),
    .out_count(cnt2), .out_ovf(oovf[2]));

  function automatic logic [15:0] get_acc(input int d);
    case (d)
      0:       return acc0;
      1:       return {8'h00, acc1};
      default: return acc2;
    endcase
  endfunction

  function automatic logic [7:0] get_cnt(input int d);
    case (d)
      0:       return cnt0;
      1:       return cnt1;
      default: return {6'b0, cnt2};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [15:0] a,
                      input logic [7:0] c, input logic o);
    exp_t e;
    e.acc = a;
    e.cnt = c;
    e.ovf = o;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    checks++;
    if (n == 0) begin
      errs++;
      $display("FAIL mon%0d: unexpected result acc=0x%0h", d, get_acc(d));
      return;
    end
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (get_acc(d) !== e.acc || get_cnt(d) !== e.cnt ||
        oovf[d] !== e.ovf) begin
      errs++;
      $display("FAIL mon%0d: got acc=0x%0h cnt=%0d ovf=%0b want acc=0x%0h cnt=%0d ovf=%0b",
               d, get_acc(d), get_cnt(d), oovf[d], e.acc, e.cnt, e.ovf);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst && ov[d] && ordy[d]) mon(d);
    end
  end

  task automatic beat(input int d, input logic [7:0] p,
                      input logic last, input logic s);
    bit ok;
    ok = 1'b0;
    iv[d]  = 1'b1;
    ip[d]  = p;
    il[d]  = last;
    sat[d] = s;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ird[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      errs++;
      checks++;
      $display("FAIL beat%0d: in_ready timeout", d);
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    il[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      iv[d] = 0; il[d] = 0; sat[d] = 0; ordy[d] = 1; ip[d] = 8'h00;
    end
    #12;
    check("rst_acc", acc0, 0);
    check("rst_valid", ov[0], 0);
    check("rst_ready", ird[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_ready", ird[0], 1);

    // Frame of three beats: 2*5 + 5*2 + (-1)*(-5) = 25
    push(0, 16'h0019, 8'd3, 1'b0);
    beat(0, 8'd10, 0, 0);
    beat(0, 8'd10, 0, 0);
    beat(0, 8'd5, 1, 0);
    check("f1_valid", ov[0], 1);
    idle(2);

    // Single-beat frame -5
    push(0, 16'hFFFB, 8'd1, 1'b0);
    beat(0, 8'hFB, 1, 0);
    check("f2_valid", ov[0], 1);
    check("f2_ready", ird[0], 0);
    idle(2);

    // 8-bit accumulator: saturate, wrap, negative saturate, sticky ovf
    push(1, 16'h007F, 8'd2, 1'b1);
    beat(1, 8'd100, 0, 1);
    beat(1, 8'd100, 1, 1);
    idle(2);
    push(1, 16'h00C8, 8'd2, 1'b1);
    beat(1, 8'd100, 0, 0);
    beat(1, 8'd100, 1, 0);
    idle(2);
    push(1, 16'h0080, 8'd2, 1'b1);
    beat(1, 8'h9C, 0, 1);
    beat(1, 8'h9C, 1, 1);
    idle(2);
    push(1, 16'h001B, 8'd3, 1'b1);
    beat(1, 8'd100, 0, 1);
    beat(1, 8'd100, 0, 1);
    beat(1, 8'h9C, 1, 1);
    idle(2);

    // Backpressure with in_valid held high
    ordy[0] = 1'b0;
    push(0, 16'h0019, 8'd3, 1'b0);
    beat(0, 8'd10, 0, 0);
    beat(0, 8'd10, 0, 0);
    beat(0, 8'd5, 1, 0);
    iv[0] = 1'b1;
    ip[0] = 8'h7F;
    il[0] = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_valid", ov[0], 1);
      check("bp_ready", ird[0], 0);
      check("bp_acc", acc0, 16'h0019);
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    check("hs_acc", acc0, 0);
    check("hs_ready", ird[0], 1);
    check("hs_valid", ov[0], 0);
    iv[0] = 1'b0;
    il[0] = 1'b0;
    idle(2);

    // Reset mid-frame discards the partial sum
    beat(0, 8'd10, 0, 0);
    beat(0, 8'd10, 0, 0);
    check("pre_rst_acc", acc0, 16'd20);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_acc", acc0, 0);
    check("mid_rst_cnt", cnt0, 0);
    check("mid_rst_valid", ov[0], 0);
    check("mid_rst_ready", ird[0], 0);
    @(negedge clk);
    rst = 1'b0;
    push(0, 16'h0005, 8'd1, 1'b0);
    beat(0, 8'd5, 1, 0);
    idle(2);

    // 2-bit counter saturates; idle gaps change nothing
    push(2, 16'h0006, 8'd3, 1'b0);
    beat(2, 8'd1, 0, 0);
    beat(2, 8'd1, 0, 0);
    ip[2] = 8'h55;
    idle(3);
    check("gap_acc", acc2, 16'd2);
    check("gap_cnt", cnt2, 2);
    beat(2, 8'd1, 0, 0);
    beat(2, 8'd1, 0, 0);
    beat(2, 8'd1, 0, 0);
    beat(2, 8'd1, 1, 0);
    idle(4);

    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
